// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory request/response interface.
package dmem_pkg;

    localparam int DMEM_TAG_WIDTH = 5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic                      write;
        logic [1:0]                size;
        logic [31:0]               addr;
        logic [3:0]                byte_en;
        logic [31:0]               wdata;
        logic [DMEM_TAG_WIDTH-1:0] tag;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0]               rdata;
        logic [DMEM_TAG_WIDTH-1:0] tag;
        logic                      error;
    } dmem_resp_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        return ((size == SIZE_HALF) && offset[0]) || ((size == SIZE_WORD) && (offset != 2'd0));
    endfunction

endpackage

// File: rtl/bram_1r1w.sv
// Simple dual-port RAM with per-column write enables and a registered read port.
module bram_1r1w #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                           clk,
    input  logic [NUM_COL-1:0]             we,
    input  logic [ADDR_WIDTH-1:0]          waddr,
    input  logic [NUM_COL*COL_WIDTH-1:0]   wdata,
    input  logic                           re,
    input  logic [ADDR_WIDTH-1:0]          raddr,
    output logic [NUM_COL*COL_WIDTH-1:0]   rdata
);
    logic [NUM_COL*COL_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [NUM_COL*COL_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_COL; i++) begin
            if (we[i]) begin
                mem[waddr][i*COL_WIDTH +: COL_WIDTH] <= wdata[i*COL_WIDTH +: COL_WIDTH];
            end
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_resp_fifo.sv
// Small register FIFO with occupancy count and a synchronous clear that beats push/pop.
module dmem_resp_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: 16 KB byte-enabled RAM, one request per cycle, in-order load responses.
// Optional alignment checking with error responses is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int RESP_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_size,
    input  logic [31:0]               req_addr,
    input  logic [3:0]                req_byte_en,
    input  logic [31:0]               req_wdata,
    input  logic [DMEM_TAG_WIDTH-1:0] req_tag,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_rdata,
    output logic [DMEM_TAG_WIDTH-1:0] resp_tag,
    output logic                      resp_error
);
    localparam int CNT_W = $clog2(RESP_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(RESP_DEPTH);

    dmem_req_t                  req;
    dmem_resp_t                 push_entry;
    dmem_resp_t                 head_entry;
    logic [$bits(dmem_resp_t)-1:0] head_bits;
    logic                       misaligned;
    logic                       accepted;
    logic                       respond;
    logic                       push;
    logic                       pop;
    logic [CNT_W-1:0]           count;
    logic [CNT_W:0]             credit_used;
    logic [3:0]                 ram_we;
    logic [31:0]                ram_rdata;
    logic                       inflight_reg;
    logic [DMEM_TAG_WIDTH-1:0]  inflight_tag_reg;
    logic                       inflight_err_reg;
    logic                       unused_bits;

    assign req = '{write: req_write, size: req_size, addr: req_addr,
                   byte_en: req_byte_en, wdata: req_wdata, tag: req_tag};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned  = is_misaligned(req.size, req.addr[1:0]);
    assign unused_bits = ^req.addr[31:ADDR_WIDTH+2];
`else
    assign misaligned  = 1'b0;
    assign unused_bits = ^{req.addr[31:ADDR_WIDTH+2], req.addr[1:0], req.size};
`endif

    // Credits cover both queued responses and the one still reading the RAM.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight_reg};
    assign req_ready   = !flush && (credit_used < DEPTH_L);
    assign accepted    = req_valid && req_ready;
    assign respond     = accepted && (!req.write || misaligned);
    assign ram_we      = (accepted && req.write && !misaligned) ? req.byte_en : 4'b0000;

    bram_1r1w #(
        .NUM_COL    (4),
        .COL_WIDTH  (8),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (req.addr[ADDR_WIDTH+1:2]),
        .wdata (req.wdata),
        .re    (accepted && !req.write),
        .raddr (req.addr[ADDR_WIDTH+1:2]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_reg     <= 1'b0;
            inflight_tag_reg <= '0;
            inflight_err_reg <= 1'b0;
        end else if (flush) begin
            inflight_reg     <= 1'b0;
        end else begin
            inflight_reg <= respond;
            if (respond) begin
                inflight_tag_reg <= req.tag;
                inflight_err_reg <= misaligned;
            end
        end
    end

    assign push       = inflight_reg && !flush;
    assign push_entry = '{rdata: (inflight_err_reg ? 32'h0 : ram_rdata),
                          tag: inflight_tag_reg, error: inflight_err_reg};
    assign pop        = resp_valid && resp_ready;

    dmem_resp_fifo #(
        .WIDTH ($bits(dmem_resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_bits),
        .count     (count)
    );

    // Mask the storage contents so idle outputs read as zero.
    assign head_entry = head_bits;
    assign resp_valid = (count != '0);
    assign resp_rdata = resp_valid ? head_entry.rdata : 32'h0;
    assign resp_tag   = resp_valid ? head_entry.tag : '0;
    assign resp_error = resp_valid && head_entry.error;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, corner-case sequences, and random traffic vs a queue model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [3:0]  req_byte_en = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_tag = 5'd0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_tag;
    logic        resp_error;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(12), .RESP_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_addr    (req_addr),
        .req_byte_en (req_byte_en),
        .req_wdata   (req_wdata),
        .req_tag     (req_tag),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_tag    (resp_tag),
        .resp_error  (resp_error)
    );

    // Model: a word array plus the ordered list of responses owed, each with its earliest visible cycle.
    typedef struct { logic [31:0] rdata; logic [4:0] tag; logic err; int vis; } exp_t;
    typedef struct { bit w; logic [1:0] sz; logic [31:0] a; logic [3:0] be; logic [31:0] wd; logic [4:0] tg; logic [31:0] exp; } vec_t;

    exp_t        q[$];
    logic [31:0] ref_mem [4096];
    vec_t        tbl[11];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        obs_valid, obs_ready, obs_error;
    logic [31:0] obs_rdata;
    logic [4:0]  obs_tag;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit tb_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_MISALIGN_CHECK_EN
        return (sz == SIZE_HALF && a[0]) || (sz == SIZE_WORD && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive, check against the model at the falling edge, advance the model at the rising edge.
    task automatic tick(input bit v, input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd, input logic [4:0] tg,
                        input bit rr, input bit fl);
        bit exp_ready, exp_valid, acc, pop, mis;
        int wi;
        req_valid = v; req_write = w; req_size = sz; req_addr = a;
        req_byte_en = be; req_wdata = wd; req_tag = tg; resp_ready = rr; flush = fl;
        @(negedge clk);
        exp_ready = !fl && (q.size() < DEPTH);
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        obs_valid = resp_valid; obs_ready = req_ready; obs_rdata = resp_rdata;
        obs_tag = resp_tag; obs_error = resp_error;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("resp_valid", 32'(resp_valid), 32'(exp_valid));
        if (exp_valid && resp_valid) begin
            check("resp_rdata", resp_rdata, q[0].rdata);
            check("resp_tag", 32'(resp_tag), 32'(q[0].tag));
            check("resp_error", 32'(resp_error), 32'(q[0].err));
        end
        acc = v && exp_ready;
        pop = exp_valid && rr;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) begin
                $display("resp tag=%0d rdata=%h err=%0b", q[0].tag, q[0].rdata, q[0].err);
                void'(q.pop_front());
            end
            if (acc) begin
                mis = tb_mis(sz, a);
                wi  = int'(a[13:2]);
                if (w && !mis) begin
                    for (int i = 0; i < 4; i++) begin
                        if (be[i]) ref_mem[wi][8*i +: 8] = wd[8*i +: 8];
                    end
                end
                if (!w || mis) q.push_back('{(mis ? 32'h0 : ref_mem[wi]), tg, mis, cyc + 2});
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input bit rr, input bit fl);
        tick(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 5'd0, rr, fl);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_acc;

        tbl[0]  = '{1'b1, SIZE_WORD, 32'h0000_0010, 4'hF,    32'hDEADBEEF, 5'd0,  32'h0};
        tbl[1]  = '{1'b0, SIZE_WORD, 32'h0000_0010, 4'h0,    32'h0,        5'd7,  32'hDEADBEEF};
        tbl[2]  = '{1'b1, SIZE_BYTE, 32'h0000_0012, 4'b0100, 32'h00AA0000, 5'd0,  32'h0};
        tbl[3]  = '{1'b0, SIZE_WORD, 32'h0000_0010, 4'h0,    32'h0,        5'd3,  32'hDEAABEEF};
        tbl[4]  = '{1'b1, SIZE_WORD, 32'h0000_0014, 4'hF,    32'h01020304, 5'd0,  32'h0};
        tbl[5]  = '{1'b1, SIZE_HALF, 32'h0000_0014, 4'b0011, 32'h00005566, 5'd0,  32'h0};
        tbl[6]  = '{1'b0, SIZE_WORD, 32'h0000_0014, 4'h0,    32'h0,        5'd9,  32'h01025566};
        tbl[7]  = '{1'b1, SIZE_WORD, 32'h0000_3FFC, 4'hF,    32'hCAFEF00D, 5'd0,  32'h0};
        tbl[8]  = '{1'b1, SIZE_WORD, 32'h0000_3FFC, 4'h0,    32'h12345678, 5'd0,  32'h0};
        tbl[9]  = '{1'b0, SIZE_WORD, 32'h0000_3FFC, 4'h0,    32'h0,        5'd31, 32'hCAFEF00D};
        tbl[10] = '{1'b0, SIZE_WORD, 32'hFFFF_C010, 4'h0,    32'h0,        5'd1,  32'hDEAABEEF};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_tag", 32'(resp_tag), 32'h0);
        check("rst_resp_error", 32'(resp_error), 32'h0);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        rst = 1'b1;

        // Directed vectors: loads must show up exactly two cycles after acceptance
        foreach (tbl[i]) begin
            tick(1'b1, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].be, tbl[i].wd, tbl[i].tg, 1'b1, 1'b0);
            if (!tbl[i].w) begin
                idle(1'b1, 1'b0);
                check("vec_lat1_valid", 32'(obs_valid), 32'h0);
                idle(1'b1, 1'b0);
                check("vec_lat2_valid", 32'(obs_valid), 32'h1);
                check("vec_rdata", obs_rdata, tbl[i].exp);
                check("vec_tag", 32'(obs_tag), 32'(tbl[i].tg));
            end
        end

        // Known contents for the random window (words 0..15)
        for (int wi = 0; wi < 16; wi++) begin
            tick(1'b1, 1'b1, SIZE_WORD, 32'(wi * 4), 4'hF, $urandom, 5'd0, 1'b1, 1'b0);
        end

        // Backpressure: exactly DEPTH loads get in, then drain in order
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, SIZE_WORD, 32'(i * 4), 4'h0, 32'h0, 5'(10 + i), 1'b0, 1'b0);
            if (obs_ready) n_acc++;
        end
        check("bp_accepted", 32'(n_acc), 32'd4);
        check("bp_ready_low", 32'(obs_ready), 32'h0);
        repeat (6) idle(1'b1, 1'b0);
        check("bp_ready_back", 32'(obs_ready), 32'h1);

        // Flush with three loads outstanding
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, SIZE_WORD, 32'(i * 4), 4'h0, 32'h0, 5'(20 + i), 1'b0, 1'b0);
        end
        idle(1'b0, 1'b0);
        idle(1'b1, 1'b1);
        check("flush_ready_low", 32'(obs_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1, 1'b0);
            check("flush_no_stale", 32'(obs_valid), 32'h0);
        end
        tick(1'b1, 1'b0, SIZE_WORD, 32'h8, 4'h0, 32'h0, 5'd5, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("post_flush_valid", 32'(obs_valid), 32'h1);
        check("post_flush_tag", 32'(obs_tag), 32'd5);

        // Random traffic inside the known window, upper address bits aliased
        for (int n = 0; n < 400; n++) begin
            tick(($urandom_range(9) < 7), 1'($urandom_range(2) == 0), 2'($urandom_range(2)),
                 ($urandom & 32'hFFFF_C03F), 4'($urandom), $urandom, 5'($urandom_range(31)),
                 ($urandom_range(9) < 6), ($urandom_range(99) < 3));
        end
        repeat (6) idle(1'b1, 1'b0);

        // Asynchronous reset with two responses pending; RAM survives
        tick(1'b1, 1'b0, SIZE_WORD, 32'h4, 4'h0, 32'h0, 5'd1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, SIZE_WORD, 32'h8, 4'h0, 32'h0, 5'd2, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        check("pre_rst_valid", 32'(obs_valid), 32'h1);
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(resp_valid), 32'h0);
        check("async_rst_tag", 32'(resp_tag), 32'h0);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1'b1, 1'b0);
        check("post_rst_ready", 32'(obs_ready), 32'h1);
        tick(1'b1, 1'b0, SIZE_WORD, 32'h0000_3FFC, 4'h0, 32'h0, 5'd17, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("post_rst_rdata", obs_rdata, 32'hCAFEF00D);

`ifdef DMEM_MISALIGN_CHECK_EN
        tick(1'b1, 1'b1, SIZE_WORD, 32'h0000_0021, 4'hF, 32'h55555555, 5'd12, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("mis_error", 32'(obs_error), 32'h1);
        check("mis_rdata", obs_rdata, 32'h0);
        tick(1'b1, 1'b0, SIZE_WORD, 32'h0000_0020, 4'h0, 32'h0, 5'd13, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        check("mis_old_data", obs_rdata, ref_mem[8]);
`endif

        repeat (3) idle(1'b1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-memory request/response interface that the load/store unit drives.
- Owns a 16 KB byte-enabled on-chip RAM.
- Accepts one request per cycle with a valid/ready handshake, performs stores immediately, and returns load data through a response FIFO that honours consumer backpressure.
- Sits between the LSU request port and the writeback/response path.

Parameters:
- ADDR_WIDTH, 12, word-address bits (4096 x 32-bit words = 16 KB).
- RESP_DEPTH, 4, response FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  core clock
- rst  input  1  reset, asynchronous, active-low
- flush  input  1  discard all pending load responses
- req_valid  input  1  request present
- req_ready  output  1  responder can accept the request this cycle
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  SIZE_BYTE / SIZE_HALF / SIZE_WORD
- req_addr  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word
- req_byte_en  input  4  lane-aligned write enables (stores only)
- req_wdata  input  32  lane-aligned store data
- req_tag  input  5  destination register index, returned unchanged
- resp_valid  output  1  load response available
- resp_ready  input  1  consumer takes the response this cycle
- resp_rdata  output  32  raw aligned 32-bit word; the consumer performs lane select and extension
- resp_tag  output  5  tag of the load being answered
- resp_error  output  1  access fault (optional feature only; otherwise tied 0)

Behaviour:
- Reset (rst low, async): FIFO pointers and count = 0, in-flight flag = 0. Outputs: resp_valid = 0, resp_tag = 0, resp_error = 0, req_ready = 1 after reset deasserts. RAM contents are not reset.
- Accept: accepted = req_valid & req_ready.
- req_ready = !flush & ((count + inflight) < RESP_DEPTH). Computed from registered state only; there is no combinational path from resp_ready.
- Store accepted in cycle N: RAM bytes with req_byte_en[i] = 1 are written at the end of cycle N. No response is produced. A store with byte_en = 0 is legal and has no effect.
- Load accepted in cycle N: RAM read issued in N and data valid in N+1. The in-flight stage carries tag/error. The entry is pushed into the FIFO at the end of N+1, so resp_valid rises in N+2 at minimum.
- In-flight register: set by an accepted load, cleared otherwise. It counts against capacity until pushed.
- FIFO: push and pop in the same cycle are allowed and leave count unchanged. Pop occurs when resp_valid & resp_ready. Pointers wrap modulo RESP_DEPTH. Count never exceeds RESP_DEPTH, which the credit rule guarantees.
- Ordering: responses are returned strictly in request order.
- Load after store: a load accepted in cycle N+1 to the same word as a store in N sees the new data. Same-cycle read/write collision cannot occur because there is one request per cycle.
- Steady state: with RESP_DEPTH >= 3 and resp_ready held high, one load per cycle is sustained.
- Flush (synchronous, 1 cycle):
  - Clears the FIFO and in-flight stage at the clock edge; resp_valid = 0 in the next cycle.
  - req_ready = 0 during the flush cycle, so nothing is accepted.
  - Stores performed before the flush remain written.
- Flush and pop in the same cycle: the flush wins. The pop is not counted, but the data was already visible and consumed.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - A request with SIZE_HALF and addr[0] = 1, or SIZE_WORD and addr[1:0] != 0, is misaligned.
  - A misaligned store is suppressed (no RAM write) and produces a response with resp_error = 1 and resp_rdata = 0.
  - A misaligned load produces resp_error = 1 and resp_rdata = 0.
  - Error responses follow the same latency, credit and ordering rules as loads.
- Undefined: no checking. Address bits [1:0] are ignored for the word index, resp_error is tied 0, and stores never respond.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SIZE_BYTE = 2'd0, SIZE_HALF = 2'd1, SIZE_WORD = 2'd2;
  - typedefs dmem_req_t and dmem_resp_t (struct of the port groups above);
  - constant DMEM_TAG_WIDTH = 5.
- Sub-module dmem_resp_fifo: a synchronous FIFO with count output and synchronous clear.
- The RAM is the existing bram_1r1w with NUM_COL = 4.

Test Plan:
- SW 0xDEADBEEF to addr 0x10, then LW 0x10 tag 7 -> two cycles later resp_valid = 1, rdata = 0xDEADBEEF, tag = 7.
- SB byte_en 4'b0100, wdata 0x00AA0000 to addr 0x12 over the word above, then LW 0x10 -> rdata = 0xDEAABEEF.
- resp_ready held 0, loads issued every cycle -> exactly 4 accepted, then req_ready = 0. Release resp_ready -> 4 responses in order, then req_ready returns to 1.
- 3 loads outstanding, flush pulsed -> resp_valid = 0 the next cycle, no stale tag ever appears; a subsequent LW returns correct data.
- rst asserted mid-burst with 2 responses pending -> resp_valid drops asynchronously. After release req_ready = 1, and RAM data written before reset remains readable.
- DMEM_MISALIGN_CHECK_EN: SW to 0x21 -> resp_error = 1, rdata = 0; LW 0x20 shows the old contents unchanged.
